id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  - ID/EX pipeline register of the 5-stage MIPS datapath. Captures the decoded instruction:
//    PC, register operands, the 32-bit extended immediate from the ID-stage sign/zero extender,
//    register addresses and control bits. Presents them to the EX stage.
//  - Contains the load-use hazard detector and inserts bubbles for stall and flush.
//  - Debug-unit hooks: single-step gating and a count of valid instructions captured.
// PARAMETERS
//  DATA_W      32  width of PC, operands and immediate
//  REG_ADDR_W  5   register-file address width
//  CTRL_W      11  control bundle width (bit layout in package)
//  CNT_W       16  width of the debug instruction counter
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           synchronous reset, active low
//  stall_i      in   1           downstream stall: hold all contents
//  flush_i      in   1           kill the ID instruction (branch taken): capture a bubble
//  dbg_mode_i   in   1           1 = advance only on dbg_step_i
//  dbg_step_i   in   1           one-cycle step pulse (meaningful only in debug mode)
//  dbg_clr_i    in   1           clear ex_count_o
//  id_valid_i   in   1           ID holds a real instruction
//  id_pc_i      in   DATA_W      PC+4 of the ID instruction
//  id_rs_data_i in   DATA_W      rs read data
//  id_rt_data_i in   DATA_W      rt read data
//  id_imm_i     in   DATA_W      extended immediate from the extender
//  id_rs_i, id_rt_i, id_rd_i  in  REG_ADDR_W  register addresses
//  id_ctrl_i    in   CTRL_W      decoded control bundle
//  ex_*_o       out  same as id_*  registered copies (valid, pc, rs/rt data, imm, rs, rt, rd, ctrl)
//  load_use_o   out  1           combinational: hold PC and IF/ID this cycle
//  ex_count_o   out  CNT_W       valid instructions captured into EX
// BEHAVIOUR
//  - Reset: when rst_n=0 at a clock edge, all ex_* outputs and ex_count_o clear to 0.
//    A bubble is all-zero. Reset mid-operation discards the held instruction.
//  - Ctrl layout:
//    - [0] reg_write, [1] mem_to_reg, [2] mem_read, [3] mem_write
//    - [4] branch, [5] alu_src, [6] reg_dst, [10:7] alu_op
//  - load_use_o = ex_valid_o & ex_ctrl_o[2] & (ex_rt_o != 0) & id_valid_i
//                 & (ex_rt_o == id_rs_i | ex_rt_o == id_rt_i).
//    - Purely combinational.
//    - Reported regardless of stall or debug gating.
//  - adv = ~dbg_mode_i | dbg_step_i. Per-edge update, priority high to low:
//    1. ~rst_n: clear everything.
//    2. ~adv or stall_i: hold all contents.
//       - flush_i is not honoured while holding; the controller keeps it asserted.
//    3. flush_i or load_use_o or ~id_valid_i: load a bubble (ex_valid_o=0, all fields 0).
//    4. Otherwise: capture all id_* inputs and set ex_valid_o=1.
//  - Latency: one cycle from ID to EX.
//    - After a load-use bubble, the dependent instruction enters on the next advancing edge.
//  - ex_count_o increments (wrapping at 2^CNT_W) on every case-4 capture.
//    - dbg_clr_i forces it to 0 and beats a simultaneous increment.
//    - dbg_clr_i does not clear while rst_n is 1 and case 2 applies? No: the clear works in any state.
//  - Immediate is stored bit-exact; no re-extension here.
//  - id_imm_i upper half is 0xFFFF or 0x0000 as delivered by the extender.
// STRUCTURE
//  - Package id_ex_pkg holds:
//    - CTRL_W and the ctrl bit indices (CTRL_REG_WRITE ... CTRL_ALU_OP_LSB/MSB).
//    - The localparam BUBBLE_CTRL = '0.
//    - A typedef for the ctrl bundle.
//  - One sub-module, load_use_detect: combinational hazard compare producing load_use_o.
//  - The register bank and counter stay in id_ex_pipe_reg.
// TESTING
//  1. Reset and capture:
//     - Stimulus: rst_n=0 for 2 cycles, then id_imm_i=32'hFFFF8000, ctrl=11'h021, valid=1.
//     - Response: outputs 0 during reset; ex_imm_o=32'hFFFF8000, ex_valid_o=1 and ex_count_o=1
//       after the next edge.
//  2. Load-use:
//     - Stimulus: EX holds lw (ctrl[2]=1) with rt=8; ID has rs=8.
//     - Response: load_use_o=1 and a bubble is captured; the next edge captures the ID
//       instruction; ex_count_o increments by 1 only.
//  3. Register $0:
//     - Stimulus: EX lw with rt=0; ID rs=0.
//     - Response: load_use_o=0 and the instruction is captured normally.
//  4. Stall vs flush:
//     - Stimulus: stall_i=1 and flush_i=1 for 3 cycles, then stall_i=0 with flush_i=1.
//     - Response: contents are unchanged for 3 edges, then a bubble is loaded.
//  5. Debug step:
//     - Stimulus: dbg_mode_i=1 with no step for 4 cycles, then a single dbg_step_i pulse.
//     - Response: outputs are frozen for 4 edges; exactly one capture happens on the pulse.
//  6. Counter:
//     - Stimulus: preload via 65535 captures, then one more capture; then assert dbg_clr_i
//       together with a capture.
//     - Response: the count wraps to 0; it reads 0 after the clear.

Source files
------------

// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared definitions for the ID/EX pipeline register.
// Holds the control-bundle width, the bit position of every control
// signal inside the bundle, the bundle typedef and the bubble encoding.
package id_ex_pkg;

    localparam int CTRL_W = 11;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_REG_DST    = 6;
    localparam int CTRL_ALU_OP_LSB = 7;
    localparam int CTRL_ALU_OP_MSB = 10;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // A bubble carries no side effects: every control bit deasserted.
    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// load_use_detect: combinational load-use hazard compare.
// Ports:
//   ex_valid    in   instruction in EX is real
//   ex_mem_read in   instruction in EX is a load
//   ex_rt       in   load destination register in EX
//   id_valid    in   instruction in ID is real
//   id_rs/id_rt in   source registers of the ID instruction
//   load_use    out  ID consumes the value the EX load has not produced yet
module load_use_detect
    import id_ex_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  load_use
);

    logic rt_nonzero;
    logic rt_match;

    // $0 is hard-wired to zero, so a load "into" it never creates a dependency.
    assign rt_nonzero = (ex_rt != '0);
    assign rt_match   = (ex_rt == id_rs) || (ex_rt == id_rt);
    assign load_use   = ex_valid && ex_mem_read && rt_nonzero && id_valid && rt_match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register of the 5-stage MIPS datapath.
// Captures PC+4, operands, extended immediate, register addresses and the
// control bundle of the ID instruction; inserts bubbles on flush, load-use
// hazard or an empty ID slot; holds on stall or when debug mode withholds
// a step; counts valid instructions entering EX.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   stall_i, flush_i           hold contents / capture a bubble
//   dbg_mode_i, dbg_step_i     single-step gating
//   dbg_clr_i                  clear the instruction counter
//   id_*_i                     decoded ID instruction
//   ex_*_o                     registered copy presented to EX
//   load_use_o                 combinational: hold PC and IF/ID this cycle
//   ex_count_o                 valid instructions captured into EX
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 11,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  dbg_mode_i,
    input  logic                  dbg_step_i,
    input  logic                  dbg_clr_i,
    input  logic                  id_valid_i,
    input  logic [DATA_W-1:0]     id_pc_i,
    input  logic [DATA_W-1:0]     id_rs_data_i,
    input  logic [DATA_W-1:0]     id_rt_data_i,
    input  logic [DATA_W-1:0]     id_imm_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic [CTRL_W-1:0]     id_ctrl_i,
    output logic                  ex_valid_o,
    output logic [DATA_W-1:0]     ex_pc_o,
    output logic [DATA_W-1:0]     ex_rs_data_o,
    output logic [DATA_W-1:0]     ex_rt_data_o,
    output logic [DATA_W-1:0]     ex_imm_o,
    output logic [REG_ADDR_W-1:0] ex_rs_o,
    output logic [REG_ADDR_W-1:0] ex_rt_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic [CTRL_W-1:0]     ex_ctrl_o,
    output logic                  load_use_o,
    output logic [CNT_W-1:0]      ex_count_o
);

    logic                  vld_p1;
    logic [DATA_W-1:0]     pc_p1;
    logic [DATA_W-1:0]     rs_data_p1;
    logic [DATA_W-1:0]     rt_data_p1;
    logic [DATA_W-1:0]     imm_p1;
    logic [REG_ADDR_W-1:0] rs_p1;
    logic [REG_ADDR_W-1:0] rt_p1;
    logic [REG_ADDR_W-1:0] rd_p1;
    logic [CTRL_W-1:0]     ctrl_p1;
    logic [CNT_W-1:0]      count_q;

    logic adv;
    logic load_en;
    logic bubble;
    logic capture;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .ex_valid    (vld_p1),
        .ex_mem_read (ctrl_p1[CTRL_MEM_READ]),
        .ex_rt       (rt_p1),
        .id_valid    (id_valid_i),
        .id_rs       (id_rs_i),
        .id_rt       (id_rt_i),
        .load_use    (load_use_o)
    );

    // A held edge ignores flush; the controller keeps flush asserted until we advance.
    assign adv     = ~dbg_mode_i | dbg_step_i;
    assign load_en = adv & ~stall_i;
    assign bubble  = flush_i | load_use_o | ~id_valid_i;
    assign capture = load_en & ~bubble;

    // ---- ID -> EX stage boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            rs_data_p1 <= '0;
            rt_data_p1 <= '0;
            imm_p1     <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rd_p1      <= '0;
            ctrl_p1    <= '0;
        end else if (load_en) begin
            if (bubble) begin
                vld_p1     <= 1'b0;
                pc_p1      <= '0;
                rs_data_p1 <= '0;
                rt_data_p1 <= '0;
                imm_p1     <= '0;
                rs_p1      <= '0;
                rt_p1      <= '0;
                rd_p1      <= '0;
                ctrl_p1    <= BUBBLE_CTRL;
            end else begin
                vld_p1     <= 1'b1;
                pc_p1      <= id_pc_i;
                rs_data_p1 <= id_rs_data_i;
                rt_data_p1 <= id_rt_data_i;
                imm_p1     <= id_imm_i;
                rs_p1      <= id_rs_i;
                rt_p1      <= id_rt_i;
                rd_p1      <= id_rd_i;
                ctrl_p1    <= id_ctrl_i;
            end
        end
    end

    // Clear beats a simultaneous increment and works even while the bank holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (dbg_clr_i) begin
            count_q <= '0;
        end else if (capture) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign ex_valid_o   = vld_p1;
    assign ex_pc_o      = pc_p1;
    assign ex_rs_data_o = rs_data_p1;
    assign ex_rt_data_o = rt_data_p1;
    assign ex_imm_o     = imm_p1;
    assign ex_rs_o      = rs_p1;
    assign ex_rt_o      = rt_p1;
    assign ex_rd_o      = rd_p1;
    assign ex_ctrl_o    = ctrl_p1;
    assign ex_count_o   = count_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of what EX must hold.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, dbg_mode_i, dbg_step_i, dbg_clr_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i, id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic [10:0] id_ctrl_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
    logic [10:0] ex_ctrl_o;
    logic        load_use_o;
    logic [15:0] ex_count_o;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_pipe_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .dbg_mode_i   (dbg_mode_i),
        .dbg_step_i   (dbg_step_i),
        .dbg_clr_i    (dbg_clr_i),
        .id_valid_i   (id_valid_i),
        .id_pc_i      (id_pc_i),
        .id_rs_data_i (id_rs_data_i),
        .id_rt_data_i (id_rt_data_i),
        .id_imm_i     (id_imm_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_rd_i      (id_rd_i),
        .id_ctrl_i    (id_ctrl_i),
        .ex_valid_o   (ex_valid_o),
        .ex_pc_o      (ex_pc_o),
        .ex_rs_data_o (ex_rs_data_o),
        .ex_rt_data_o (ex_rt_data_o),
        .ex_imm_o     (ex_imm_o),
        .ex_rs_o      (ex_rs_o),
        .ex_rt_o      (ex_rt_o),
        .ex_rd_o      (ex_rd_o),
        .ex_ctrl_o    (ex_ctrl_o),
        .load_use_o   (load_use_o),
        .ex_count_o   (ex_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // What EX holds: either nothing (all zero) or an exact copy of an ID instruction.
    typedef struct {
        logic        v;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic [10:0] ctrl;
    } ex_t;

    ex_t m;
    int  m_cnt;
    bit  chk_en = 1'b0;

    function automatic bit model_hazard();
        return m.v && m.ctrl[2] && (m.rt != 5'd0) && id_valid_i
               && ((m.rt == id_rs_i) || (m.rt == id_rt_i));
    endfunction

    always @(posedge clk) begin
        bit moves;
        if (!rst_n) begin
            m = '{v: 1'b0, pc: 32'd0, a: 32'd0, b: 32'd0, imm: 32'd0,
                  rs: 5'd0, rt: 5'd0, rd: 5'd0, ctrl: 11'd0};
            m_cnt  = 0;
            chk_en = 1'b1;
        end else begin
            moves = (!dbg_mode_i || dbg_step_i) && !stall_i;
            if (moves) begin
                if (flush_i || model_hazard() || !id_valid_i) begin
                    m = '{v: 1'b0, pc: 32'd0, a: 32'd0, b: 32'd0, imm: 32'd0,
                          rs: 5'd0, rt: 5'd0, rd: 5'd0, ctrl: 11'd0};
                end else begin
                    m = '{v: 1'b1, pc: id_pc_i, a: id_rs_data_i, b: id_rt_data_i,
                          imm: id_imm_i, rs: id_rs_i, rt: id_rt_i, rd: id_rd_i,
                          ctrl: id_ctrl_i};
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end
            if (dbg_clr_i) m_cnt = 0;
        end
    end

    // Single compare process: every falling edge, all outputs vs the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ex_valid", {63'd0, ex_valid_o}, {63'd0, m.v});
            check("ex_pc", {32'd0, ex_pc_o}, {32'd0, m.pc});
            check("ex_rs_data", {32'd0, ex_rs_data_o}, {32'd0, m.a});
            check("ex_rt_data", {32'd0, ex_rt_data_o}, {32'd0, m.b});
            check("ex_imm", {32'd0, ex_imm_o}, {32'd0, m.imm});
            check("ex_regs", {49'd0, ex_rs_o, ex_rt_o, ex_rd_o}, {49'd0, m.rs, m.rt, m.rd});
            check("ex_ctrl", {53'd0, ex_ctrl_o}, {53'd0, m.ctrl});
            check("load_use", {63'd0, load_use_o}, {63'd0, model_hazard()});
            check("ex_count", {48'd0, ex_count_o}, 64'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [10:0] ctrl);
        id_valid_i   = v;
        id_pc_i      = pc;
        id_imm_i     = imm;
        id_rs_i      = rs;
        id_rt_i      = rt;
        id_rd_i      = rd;
        id_ctrl_i    = ctrl;
        id_rs_data_i = $urandom;
        id_rt_data_i = $urandom;
    endtask

    initial begin
        int c0;
        rst_n = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0;
        dbg_mode_i = 1'b0; dbg_step_i = 1'b0; dbg_clr_i = 1'b0;
        drive_id(1'b1, 32'h4, 32'h5, 5'd1, 5'd2, 5'd3, 11'h7FF);

        // Reset, then a first capture
        repeat (2) step();
        check("rst_valid", {63'd0, ex_valid_o}, 64'd0);
        check("rst_ctrl", {53'd0, ex_ctrl_o}, 64'd0);
        check("rst_count", {48'd0, ex_count_o}, 64'd0);
        rst_n = 1'b1;
        drive_id(1'b1, 32'h0040_0004, 32'hFFFF_8000, 5'd1, 5'd2, 5'd3, 11'h021);
        step();
        check("t1_imm", {32'd0, ex_imm_o}, 64'hFFFF_8000);
        check("t1_valid", {63'd0, ex_valid_o}, 64'd1);
        check("t1_count", {48'd0, ex_count_o}, 64'd1);

        // Load-use: lw rt=8 in EX, dependent ID instruction reads rs=8
        drive_id(1'b1, 32'h100, 32'h0, 5'd4, 5'd8, 5'd0, 11'h007);
        step();
        c0 = int'(ex_count_o);
        drive_id(1'b1, 32'h104, 32'h10, 5'd8, 5'd9, 5'd10, 11'h041);
        #1;
        check("t2_load_use", {63'd0, load_use_o}, 64'd1);
        step();
        check("t2_bubble", {63'd0, ex_valid_o}, 64'd0);
        check("t2_bubble_pc", {32'd0, ex_pc_o}, 64'd0);
        step();
        check("t2_dep_valid", {63'd0, ex_valid_o}, 64'd1);
        check("t2_dep_rs", {59'd0, ex_rs_o}, 64'd8);
        check("t2_count", {48'd0, ex_count_o}, 64'(c0 + 1));

        // Load into $0 never stalls
        drive_id(1'b1, 32'h200, 32'h0, 5'd4, 5'd0, 5'd0, 11'h007);
        step();
        drive_id(1'b1, 32'h204, 32'h3, 5'd0, 5'd0, 5'd6, 11'h001);
        #1;
        check("t3_load_use", {63'd0, load_use_o}, 64'd0);
        step();
        check("t3_pc", {32'd0, ex_pc_o}, 64'h204);

        // Stall overrides flush, then flush bubbles
        drive_id(1'b1, 32'h1234, 32'h1, 5'd1, 5'd2, 5'd3, 11'h001);
        step();
        stall_i = 1'b1; flush_i = 1'b1;
        drive_id(1'b1, 32'h5678, 32'h2, 5'd1, 5'd2, 5'd3, 11'h001);
        repeat (3) begin
            step();
            check("t4_hold_pc", {32'd0, ex_pc_o}, 64'h1234);
        end
        stall_i = 1'b0;
        step();
        check("t4_flush_valid", {63'd0, ex_valid_o}, 64'd0);
        check("t4_flush_pc", {32'd0, ex_pc_o}, 64'd0);
        flush_i = 1'b0;

        // Debug single step
        drive_id(1'b1, 32'h100, 32'h0, 5'd1, 5'd2, 5'd3, 11'h001);
        step();
        c0 = int'(ex_count_o);
        dbg_mode_i = 1'b1;
        drive_id(1'b1, 32'h200, 32'h0, 5'd1, 5'd2, 5'd3, 11'h001);
        repeat (4) begin
            step();
            check("t5_frozen_pc", {32'd0, ex_pc_o}, 64'h100);
        end
        dbg_step_i = 1'b1;
        step();
        dbg_step_i = 1'b0;
        check("t5_step_pc", {32'd0, ex_pc_o}, 64'h200);
        drive_id(1'b1, 32'h300, 32'h0, 5'd1, 5'd2, 5'd3, 11'h001);
        step();
        check("t5_after_pc", {32'd0, ex_pc_o}, 64'h200);
        check("t5_count", {48'd0, ex_count_o}, 64'(c0 + 1));
        dbg_mode_i = 1'b0;

        // Randomized traffic, including mid-run resets
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 63) != 0);
            stall_i    = ($urandom_range(0, 7) == 0);
            flush_i    = ($urandom_range(0, 7) == 0);
            dbg_mode_i = ($urandom_range(0, 3) == 0);
            dbg_step_i = ($urandom_range(0, 1) == 0);
            dbg_clr_i  = ($urandom_range(0, 31) == 0);
            drive_id($urandom_range(0, 3) != 0, $urandom, $urandom,
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                     ($urandom_range(0, 1) != 0) ? (11'($urandom) | 11'h004) : 11'($urandom));
            step();
        end

        // Counter wrap and clear
        rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        dbg_mode_i = 1'b0; dbg_step_i = 1'b0;
        dbg_clr_i = 1'b1;
        drive_id(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 11'h000);
        step();
        dbg_clr_i = 1'b0;
        check("t6_cleared", {48'd0, ex_count_o}, 64'd0);
        drive_id(1'b1, 32'h400, 32'h0, 5'd1, 5'd2, 5'd3, 11'h001);
        repeat (65535) step();
        check("t6_full", {48'd0, ex_count_o}, 64'hFFFF);
        step();
        check("t6_wrap", {48'd0, ex_count_o}, 64'd0);
        step();
        check("t6_one", {48'd0, ex_count_o}, 64'd1);
        dbg_clr_i = 1'b1;
        step();
        dbg_clr_i = 1'b0;
        check("t6_clr_beats_inc", {48'd0, ex_count_o}, 64'd0);
        check("t6_clr_capture", {63'd0, ex_valid_o}, 64'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
